// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine: UNROLL rounds per clock, chains H across blocks, valid/ready digest.
// Optional SHA224_EN adds the SHA-224 IV and truncated digest, selected by mode on a message's first block.
module sha256_block_engine #(
  parameter int UNROLL = 1,
  parameter int DIG_W  = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [511:0]     blk_data,
  input  logic             blk_first,
  input  logic             blk_last,
  input  logic             mode,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [DIG_W-1:0] hash_digest,
  output logic             busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("sha256_block_engine: UNROLL must be 1, 2 or 4");
  end
  if (DIG_W != 256) begin : g_bad_dig_w
    $error("sha256_block_engine: DIG_W must be 256");
  end

  localparam logic [5:0] RC_STEP = 6'(UNROLL);
  localparam logic [5:0] RC_LAST = 6'(64 - UNROLL);

  localparam logic [31:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

`ifdef SHA224_EN
  localparam logic [31:0] IV224 [0:7] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUNDS, S_FINAL, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_init;
  logic [5:0]       r_rc;
  logic             r_last;
  logic [31:0]      r_h   [0:7];
  logic [31:0]      r_wv  [0:7];
  logic [31:0]      r_w   [0:15];
  logic [DIG_W-1:0] r_digest;
  logic             w_accept;
  logic [31:0]      w_iv    [0:7];
  logic [31:0]      w_hsum  [0:7];
  logic [31:0]      w_sched [0:15+UNROLL];
  logic [31:0]      w_rnd   [0:UNROLL][0:7];
  logic [DIG_W-1:0] w_dig;

`ifdef SHA224_EN
  logic             r_mode;
`else
  logic             w_unused_mode;
  assign w_unused_mode = mode;
`endif

  // Control FSM
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    blk_ready = 1'b0;
    busy      = 1'b0;
    dig_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        blk_ready = r_init;
        if (blk_valid && r_init) w_next = S_ROUNDS;
      end
      S_ROUNDS: begin
        busy = 1'b1;
        if (r_rc == RC_LAST) w_next = S_FINAL;
      end
      S_FINAL: begin
        busy   = 1'b1;
        w_next = r_last ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        dig_valid = 1'b1;
        if (dig_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept    = blk_valid && blk_ready;
  assign hash_digest = r_digest;

  always_comb begin
    for (int i = 0; i < 8; i++) w_iv[i] = IV256[i];
`ifdef SHA224_EN
    if (mode) begin
      for (int i = 0; i < 8; i++) w_iv[i] = IV224[i];
    end
`endif
  end

  // Round datapath: message schedule window and UNROLL chained compression rounds
  always_comb begin
    logic [31:0] v_t1;
    logic [31:0] v_t2;
    logic [5:0]  v_idx;
    v_t1  = '0;
    v_t2  = '0;
    v_idx = '0;
    for (int i = 0; i < 16; i++) w_sched[i] = r_w[i];
    // Window holds W[rc..rc+15]; the words past it are produced for the next window and the later rounds
    for (int u = 0; u < UNROLL; u++) begin
      w_sched[16+u] = sml_s1(w_sched[14+u]) + w_sched[9+u] + sml_s0(w_sched[1+u]) + w_sched[u];
    end
    for (int i = 0; i < 8; i++) w_rnd[0][i] = r_wv[i];
    for (int u = 0; u < UNROLL; u++) begin
      v_idx = r_rc + 6'(u);
      v_t1  = w_rnd[u][7] + big_s1(w_rnd[u][4])
            + ((w_rnd[u][4] & w_rnd[u][5]) ^ (~w_rnd[u][4] & w_rnd[u][6]))
            + K_ROM[v_idx] + w_sched[u];
      v_t2  = big_s0(w_rnd[u][0])
            + ((w_rnd[u][0] & w_rnd[u][1]) ^ (w_rnd[u][0] & w_rnd[u][2]) ^ (w_rnd[u][1] & w_rnd[u][2]));
      w_rnd[u+1][0] = v_t1 + v_t2;
      w_rnd[u+1][1] = w_rnd[u][0];
      w_rnd[u+1][2] = w_rnd[u][1];
      w_rnd[u+1][3] = w_rnd[u][2];
      w_rnd[u+1][4] = w_rnd[u][3] + v_t1;
      w_rnd[u+1][5] = w_rnd[u][4];
      w_rnd[u+1][6] = w_rnd[u][5];
      w_rnd[u+1][7] = w_rnd[u][6];
    end
  end

  // Final feed-forward and digest packing
  always_comb begin
    w_dig = '0;
    for (int i = 0; i < 8; i++) begin
      w_hsum[i]              = r_h[i] + r_wv[i];
      w_dig[255-32*i -: 32]  = w_hsum[i];
    end
`ifdef SHA224_EN
    if (r_mode) w_dig[31:0] = '0;
`endif
  end

  // Working variables and schedule window carry no reset; they are always loaded on accept
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_accept) begin
      for (int i = 0; i < 16; i++) r_w[i] <= blk_data[511-32*i -: 32];
      for (int i = 0; i < 8; i++)  r_wv[i] <= blk_first ? w_iv[i] : r_h[i];
    end else if (r_state == S_ROUNDS) begin
      for (int i = 0; i < 16; i++) r_w[i] <= w_sched[i+UNROLL];
      for (int i = 0; i < 8; i++)  r_wv[i] <= w_rnd[UNROLL][i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_init   <= 1'b0;
      r_rc     <= '0;
      r_last   <= 1'b0;
      r_digest <= '0;
      for (int i = 0; i < 8; i++) r_h[i] <= '0;
`ifdef SHA224_EN
      r_mode   <= 1'b0;
`endif
    end else begin
      r_init <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rc   <= '0;
            r_last <= blk_last;
            if (blk_first) begin
              for (int i = 0; i < 8; i++) r_h[i] <= w_iv[i];
`ifdef SHA224_EN
              r_mode <= mode;
`endif
            end
          end
        end
        S_ROUNDS: r_rc <= r_rc + RC_STEP;
        S_FINAL: begin
          for (int i = 0; i < 8; i++) r_h[i] <= w_hsum[i];
          if (r_last) r_digest <= w_dig;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_engine.sv
// Directed-vector bench for sha256_block_engine: one instance at UNROLL=1 and one at UNROLL=4.
module tb_sha256_block_engine;

  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_2BLK  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_224   = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_2A    = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
  localparam logic [511:0] B_2B    = {480'h0, 32'h000001c0};

`ifdef SHA224_EN
  localparam logic [255:0] D_ABC_MODE1 = D_224;
`else
  localparam logic [255:0] D_ABC_MODE1 = D_ABC;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         blk_valid   [2];
  logic         blk_ready   [2];
  logic [511:0] blk_data    [2];
  logic         blk_first   [2];
  logic         blk_last    [2];
  logic         mode        [2];
  logic         dig_valid   [2];
  logic         dig_ready   [2];
  logic [255:0] hash_digest [2];
  logic         busy        [2];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  sha256_block_engine #(.UNROLL(1)) u_dut_u1 (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]), .blk_data(blk_data[0]),
    .blk_first(blk_first[0]), .blk_last(blk_last[0]), .mode(mode[0]),
    .dig_valid(dig_valid[0]), .dig_ready(dig_ready[0]), .hash_digest(hash_digest[0]),
    .busy(busy[0])
  );

  sha256_block_engine #(.UNROLL(4)) u_dut_u4 (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]), .blk_data(blk_data[1]),
    .blk_first(blk_first[1]), .blk_last(blk_last[1]), .mode(mode[1]),
    .dig_valid(dig_valid[1]), .dig_ready(dig_ready[1]), .hash_digest(hash_digest[1]),
    .busy(busy[1])
  );

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int s);
    return (s == 0) ? 65 : 17;
  endfunction

  task automatic check_outputs_zero(input int s, input string tag);
    check_val({tag, "_ctrl"}, 256'({blk_ready[s], dig_valid[s], busy[s]}), 256'(0));
    check_val({tag, "_digest"}, hash_digest[s], 256'(0));
  endtask

  task automatic send_block(input int s, input string tag, input logic [511:0] data,
                            input logic first, input logic last, input logic md);
    int n;
    @(negedge clk);
    blk_valid[s] = 1'b1;
    blk_data[s]  = data;
    blk_first[s] = first;
    blk_last[s]  = last;
    mode[s]      = md;
    n = 0;
    while (!blk_ready[s] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_accept"}, 256'(blk_ready[s]), 256'(1));
    @(posedge clk);
    #1;
    blk_valid[s] = 1'b0;
  endtask

  // Called right after the accept edge; stops on the edge that raises dig_valid
  task automatic wait_digest(input int s, input string tag, input logic [255:0] exp);
    int n;
    bit ready_seen;
    bit busy_first;
    n = 0;
    ready_seen = 1'b0;
    busy_first = 1'b0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) busy_first = busy[s];
      if (blk_ready[s]) ready_seen = 1'b1;
    end while (!dig_valid[s] && n < 300);
    check_val({tag, "_latency"}, 256'(n), 256'(lat_of(s)));
    check_val({tag, "_busy"}, 256'(busy_first), 256'(1));
    check_val({tag, "_ready_low"}, 256'(ready_seen), 256'(0));
    check_val({tag, "_digest"}, hash_digest[s], exp);
  endtask

  // Non-final block: engine must return to IDLE with no digest
  task automatic wait_chain(input int s, input string tag);
    int n;
    bit dv_seen;
    n = 0;
    dv_seen = 1'b0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (dig_valid[s]) dv_seen = 1'b1;
    end while (!blk_ready[s] && n < 300);
    check_val({tag, "_chain_cycles"}, 256'(n), 256'(lat_of(s)));
    check_val({tag, "_no_digest"}, 256'(dv_seen), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit bp_bad;
    for (int s = 0; s < 2; s++) begin
      blk_valid[s] = 1'b0;
      blk_data[s]  = '0;
      blk_first[s] = 1'b0;
      blk_last[s]  = 1'b0;
      mode[s]      = 1'b0;
      dig_ready[s] = 1'b1;
    end

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero(0, "reset_u1");
    check_outputs_zero(1, "reset_u4");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("ready_before_edge", 256'(blk_ready[0]), 256'(0));
    @(posedge clk);
    #1;
    check_val("ready_after_release_u1", 256'(blk_ready[0]), 256'(1));
    check_val("ready_after_release_u4", 256'(blk_ready[1]), 256'(1));

    send_block(0, "abc_u1", B_ABC, 1'b1, 1'b1, 1'b0);
    wait_digest(0, "abc_u1", D_ABC);

    send_block(1, "empty_u4", B_EMPTY, 1'b1, 1'b1, 1'b0);
    wait_digest(1, "empty_u4", D_EMPTY);

    for (int s = 0; s < 2; s++) begin
      send_block(s, "two_blk_a", B_2A, 1'b1, 1'b0, 1'b0);
      wait_chain(s, "two_blk_a");
      repeat (3) @(negedge clk);
      send_block(s, "two_blk_b", B_2B, 1'b0, 1'b1, 1'b0);
      wait_digest(s, "two_blk_b", D_2BLK);
    end

    for (int s = 0; s < 2; s++) begin
      send_block(s, "abc_mode1", B_ABC, 1'b1, 1'b1, 1'b1);
      wait_digest(s, "abc_mode1", D_ABC_MODE1);
      send_block(s, "abc_mode0", B_ABC, 1'b1, 1'b1, 1'b0);
      wait_digest(s, "abc_mode0", D_ABC);
    end

    dig_ready[0] = 1'b0;
    send_block(0, "bp", B_EMPTY, 1'b1, 1'b1, 1'b0);
    wait_digest(0, "bp", D_EMPTY);
    bp_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!dig_valid[0] || blk_ready[0] || hash_digest[0] !== D_EMPTY) bp_bad = 1'b1;
    end
    check_val("bp_hold", 256'(bp_bad), 256'(0));
    @(negedge clk);
    dig_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp_release", 256'({dig_valid[0], blk_ready[0]}), 256'(2'b01));
    send_block(0, "bp_again", B_ABC, 1'b1, 1'b1, 1'b0);
    wait_digest(0, "bp_again", D_ABC);

    send_block(0, "midrst", B_2A, 1'b1, 1'b1, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_val("midrst_busy_before", 256'(busy[0]), 256'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_zero(0, "midrst_u1");
    @(negedge clk);
    rst = 1'b1;
    send_block(0, "after_rst", B_ABC, 1'b1, 1'b1, 1'b0);
    wait_digest(0, "after_rst", D_ABC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
